mux_4_to_1: RTL and testbench
=============================

Name: mux_4_to_1

Overview:
- Registered 4-to-1 multiplexer.
- Two select bits (s1 = MSB, s0 = LSB) choose one of four WIDTH-bit data inputs.
- The selected word is captured into an output register on the rising clock edge.
- Used as a generic datapath selector wherever a clean, registered 4-way choice is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- out  output  WIDTH  registered selected data.
- in0  input  WIDTH  data input, selected when {s1,s0}=2'b00.
- in1  input  WIDTH  data input, selected when {s1,s0}=2'b01.
- in2  input  WIDTH  data input, selected when {s1,s0}=2'b10.
- in3  input  WIDTH  data input, selected when {s1,s0}=2'b11.
- s1  input  1  select MSB.
- s0  input  1  select LSB.
- en  input  1  capture enable; out updates only when high.
- out_valid  output  1  high for the cycle after a capture.

Behaviour:
- Reset:
  - rst_n low asserts immediately, independent of clk.
  - out = 0 and out_valid = 0 while rst_n is low.
  - The first capture is possible on the first rising edge after rst_n rises.
- Selection (combinational, internal):
  - sel = {s1,s0}: 00 -> in0, 01 -> in1, 10 -> in2, 11 -> in3.
  - All four codes are decoded explicitly. No priority logic; no latch inferred.
- Capture:
  - On rising clk with en = 1: out <= selected input, out_valid <= 1.
  - On rising clk with en = 0: out holds its value, out_valid <= 0.
- Latency:
  - Exactly one clock from data/select/en sampled to out.
  - Input or select changes between edges do not affect out until the next enabled edge.
- Simultaneous events:
  - A select change and a data change in the same cycle: the value sampled at the edge wins.
  - rst_n asserted coincident with an edge: reset wins.
- Reset mid-operation: out clears to 0 and out_valid to 0 immediately; no pending state survives.
- Width rules: no arithmetic; all paths are WIDTH bits, bit-for-bit copy.
- Unknown select (X/Z on s1 or s0) in simulation: out becomes all-X on an enabled edge. Not a defined operating mode.
- No handshake beyond en/out_valid; there is no backpressure.

Optional Feature:
- Macro: MUX_OUT_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit, after out_valid).
  - out_par is registered alongside out and equals the XOR reduction of the captured word (even parity).
  - Reset value 0; holds when en = 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with inputs active -> out = 0, out_valid = 0; release rst_n -> both remain 0 until the first enabled edge.
- Select sweep, WIDTH = 1, in0 = 1, in1 = 0, in2 = 1, in3 = 0, en = 1:
  - {s1,s0} = 00 -> out = 1 one cycle later.
  - 01 -> 0.
  - 10 -> 1.
  - 11 -> 0.
  - out_valid = 1 throughout.
- Hold: capture in2 = 1, then drop en and change sel to 11 -> out stays 1, out_valid = 0.
- Async reset mid-stream: out = 1, pulse rst_n low between edges -> out = 0 immediately, no clock needed.
- WIDTH = 8, in0 = 8'hA5, in1 = 8'h3C, in2 = 8'hFF, in3 = 8'h00, sel cycled 00..11 -> out = A5, 3C, FF, 00 on consecutive cycles.
- With MUX_OUT_PARITY_EN, WIDTH = 8, select in0 = 8'hA5 -> out_par = 0; select in1 = 8'h3D -> out_par = 1.

Source files
------------

// File: rtl/mux_4_to_1.sv
// Registered 4-to-1 multiplexer.
// {s1,s0} selects one of four WIDTH-bit words. The word is captured into the
// output register on a rising clk edge when en is high. out_valid marks the
// cycle after each capture.
// Optional build macro: MUX_OUT_PARITY_EN adds out_par, which is the even
// parity (XOR reduction) of the captured word.
module mux_4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             s1,
  input  logic             s0,
  input  logic             en,
  output logic             out_valid
`ifdef MUX_OUT_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;

  assign sel = {s1, s0};

  // Every code is decoded explicitly. An X/Z select matches no item and falls
  // through to all-X, so an undefined select shows up in simulation.
  function automatic logic [WIDTH-1:0] select_word(
    input logic [1:0]       code,
    input logic [WIDTH-1:0] w0,
    input logic [WIDTH-1:0] w1,
    input logic [WIDTH-1:0] w2,
    input logic [WIDTH-1:0] w3
  );
    logic [WIDTH-1:0] r;
    case (code)
      2'b00:   r = w0;
      2'b01:   r = w1;
      2'b10:   r = w2;
      2'b11:   r = w3;
      default: r = {WIDTH{1'bx}};
    endcase
    return r;
  endfunction

  // Combinational selection ahead of the output register.
  always_comb begin
    sel_data = select_word(sel, in0, in1, in2, in3);
  end

  // Output register. It captures on en and holds otherwise.
  // Asynchronous reset clears both data and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= en;
      if (en) begin
        data_p0 <= sel_data;
      end
    end
  end

  assign out       = data_p0;
  assign out_valid = vld_p0;

`ifdef MUX_OUT_PARITY_EN
  logic par_p0;

  // The parity bit is registered alongside the data word.
  // It has the same capture, hold and reset behaviour as the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_p0 <= 1'b0;
    end else if (en) begin
      par_p0 <= ^sel_data;
    end
  end

  assign out_par = par_p0;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Testbench for mux_4_to_1. It instantiates WIDTH=1 and WIDTH=8 copies, which
// share select, enable and reset. A stimulus process pushes the expected
// response into a queue. A monitor pops an entry one step after each rising
// edge and compares it with the outputs.
module tb_mux_4_to_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, s1, s0, en;
  logic [0:0] a0, a1, a2, a3, o1;
  logic [7:0] b0, b1, b2, b3, o8;
  logic       v1, v8;
`ifdef MUX_OUT_PARITY_EN
  logic       p1, p8;
`endif

  mux_4_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .out(o1),
    .in0(a0), .in1(a1), .in2(a2), .in3(a3),
    .s1(s1), .s0(s0), .en(en), .out_valid(v1)
`ifdef MUX_OUT_PARITY_EN
    , .out_par(p1)
`endif
  );

  mux_4_to_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .out(o8),
    .in0(b0), .in1(b1), .in2(b2), .in3(b3),
    .s1(s1), .s0(s0), .en(en), .out_valid(v8)
`ifdef MUX_OUT_PARITY_EN
    , .out_par(p8)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] d8;
    logic [0:0] d1;
    logic       p8;
    logic       p1;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;

  // Reference model: four input words per width and the last captured word.
  logic [7:0] ref8[4];
  logic [0:0] ref1[4];
  logic [7:0] m8;
  logic [0:0] m1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and record the expected result.
  task automatic issue(input int sel, input logic e);
    @(negedge clk);
    {s1, s0} = 2'(sel);
    en = e;
    b0 = ref8[0]; b1 = ref8[1]; b2 = ref8[2]; b3 = ref8[3];
    a0 = ref1[0]; a1 = ref1[1]; a2 = ref1[2]; a3 = ref1[3];
    if (e) begin
      m8 = ref8[sel];
      m1 = ref1[sel];
    end
    sbq.push_back('{e, m8, m1, ^m8, m1[0]});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout", 8'(sbq.size()), 8'd0);
      sbq.delete();
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_o1"}, 8'(o1), 8'h00);
    chk({nm, "_v1"}, 8'(v1), 8'h00);
    chk({nm, "_o8"}, o8, 8'h00);
    chk({nm, "_v8"}, 8'(v8), 8'h00);
`ifdef MUX_OUT_PARITY_EN
    chk({nm, "_p8"}, 8'(p8), 8'h00);
`endif
  endtask

  // Monitor: compare the outputs one step after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("valid1", 8'(v1), 8'(mon_e.v));
        chk("valid8", 8'(v8), 8'(mon_e.v));
        chk("out1", 8'(o1), 8'(mon_e.d1));
        chk("out8", o8, mon_e.d8);
`ifdef MUX_OUT_PARITY_EN
        chk("par1", 8'(p1), 8'(mon_e.p1));
        chk("par8", 8'(p8), 8'(mon_e.p8));
`endif
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m8 = '0;
    m1 = '0;
    rst_n = 1'b0;
    en = 1'b1;
    {s1, s0} = 2'b01;
    a0 = 1; a1 = 1; a2 = 1; a3 = 1;
    b0 = 8'h11; b1 = 8'h22; b2 = 8'h33; b3 = 8'h44;

    // Reset is held low with the inputs active.
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_hold");

    // Release reset with en low. The outputs stay zero.
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    #1;
    check_zero("rst_rel");
    ref8 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    ref1 = '{1'b1, 1'b0, 1'b1, 1'b0};
    issue(0, 1'b0);

    // Select sweep.
    for (int k = 0; k < 4; k++) issue(k, 1'b1);

    // Capture in2, then hold while the select and data change.
    issue(2, 1'b1);
    issue(3, 1'b0);
    ref8[2] = 8'h5A;
    ref1[2] = 1'b0;
    issue(2, 1'b0);
    wait_drain();

    // Pulse reset between edges. The outputs must clear without a clock edge.
    chk("pre_rst_o1", 8'(o1), 8'h01);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    m8 = '0;
    m1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 1'b0);

    // Parity cases: A5 has even parity, 3D has odd parity.
    ref8 = '{8'hA5, 8'h3D, 8'h00, 8'h00};
    ref1 = '{1'b1, 1'b0, 1'b0, 1'b0};
    issue(0, 1'b1);
    issue(1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < 4; j++) begin
        ref8[j] = 8'($urandom);
        ref1[j] = 1'($urandom);
      end
      issue(int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
